// File: rtl/demux1x4_router.sv
// 1:4 valid/ready demultiplexer with a one-entry output register per channel.
// Optional per-channel transfer counters are built when DEMUX_STATS_EN is defined.
module demux1x4_router #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic [1:0]      in_sel,
    output logic [3:0]      out_valid,
    input  logic [3:0]      out_ready,
    output logic [4*DW-1:0] out_data,
    output logic [31:0]     stat_cnt
);

    logic [3:0]    full_r;
    logic [DW-1:0] data_r [4];
    logic [3:0]    accept_s;
    logic [3:0]    pop_s;
    logic          in_ready_s;

    // A channel can take a word when empty or when its current word leaves this edge.
    assign in_ready_s = !rst && (!full_r[in_sel] || out_ready[in_sel]);
    assign in_ready   = in_ready_s;
    assign pop_s      = full_r & out_ready;
    assign out_valid  = full_r;

    // Decode which channel, if any, accepts the input word this cycle.
    always_comb begin
        accept_s = 4'b0000;
        if (in_valid && in_ready_s) begin
            case (in_sel)
                2'd0:    accept_s = 4'b0001;
                2'd1:    accept_s = 4'b0010;
                2'd2:    accept_s = 4'b0100;
                2'd3:    accept_s = 4'b1000;
                default: accept_s = 4'b0000;
            endcase
        end else begin
            accept_s = 4'b0000;
        end
    end

    // Per-channel holding register; an accept on the pop edge refills without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                data_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (accept_s[k]) begin
                    full_r[k] <= 1'b1;
                    data_r[k] <= in_data;
                end else if (pop_s[k]) begin
                    full_r[k] <= 1'b0;
                end else begin
                    full_r[k] <= full_r[k];
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_out
            assign out_data[g*DW +: DW] = data_r[g];
        end
    endgenerate

`ifdef DEMUX_STATS_EN
    logic [7:0] cnt_r [4];

    // Free-running 8-bit pop counters; wrap silently at 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                cnt_r[k] <= 8'd0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (pop_s[k]) begin
                    cnt_r[k] <= cnt_r[k] + 8'd1;
                end else begin
                    cnt_r[k] <= cnt_r[k];
                end
            end
        end
    end

    assign stat_cnt = {cnt_r[3], cnt_r[2], cnt_r[1], cnt_r[0]};
`else
    assign stat_cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_demux1x4_router.sv
// Self-checking bench for demux1x4_router: directed scenarios plus a randomized
// phase, all checked against a per-channel queue model of the router.
module tb_demux1x4_router;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   in_data = '0;
    logic [1:0]      in_sel = 2'd0;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready = 4'h0;
    logic [4*DW-1:0] out_data;
    logic [31:0]     stat_cnt;

    demux1x4_router #(.DW(DW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stat_cnt(stat_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: each channel is a queue holding at most one word.
    logic [DW-1:0] mq [4][$];
    logic [DW-1:0] last_word [4];
    int            pops [4];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic          last_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_stat();
        logic [31:0] s;
        s = 32'h0;
`ifdef DEMUX_STATS_EN
        for (int k = 0; k < 4; k++) s[k*8 +: 8] = 8'(pops[k] % 256);
`endif
        return s;
    endfunction

    // One clock cycle: drive inputs, check in_ready, clock, update model, check outputs.
    task automatic cycle(input logic r, input logic v, input logic [1:0] s,
                         input logic [DW-1:0] d, input logic [3:0] rdy);
        logic       exp_rdy;
        logic [3:0] pop_now;
        logic [3:0] ev;
        logic [4*DW-1:0] ed;
        rst = r; in_valid = v; in_sel = s; in_data = d; out_ready = rdy;
        #1;
        exp_rdy = !r && ((mq[s].size() == 0) || rdy[s]);
        chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
        @(posedge clk);
        last_acc = v && exp_rdy;
        for (int k = 0; k < 4; k++) pop_now[k] = (mq[k].size() != 0) && rdy[k];
        if (r) begin
            for (int k = 0; k < 4; k++) begin
                mq[k].delete();
                pops[k] = 0;
                last_word[k] = '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (pop_now[k]) begin
                    void'(mq[k].pop_front());
                    pops[k]++;
                end
            end
            if (last_acc) begin
                mq[s].push_back(d);
                last_word[s] = d;
            end
        end
        #1;
        for (int k = 0; k < 4; k++) begin
            ev[k] = (mq[k].size() != 0);
            ed[k*DW +: DW] = ev[k] ? mq[k][0] : last_word[k];
        end
        chk("out_valid", {60'd0, out_valid}, {60'd0, ev});
        chk("out_data", {32'd0, out_data}, {32'd0, ed});
        chk("stat_cnt", {32'd0, stat_cnt}, {32'd0, exp_stat()});
    endtask

    logic          pend;
    logic [1:0]    p_sel;
    logic [DW-1:0] p_dat;
    int            guard;

    initial begin
        for (int k = 0; k < 4; k++) begin
            pops[k] = 0;
            last_word[k] = '0;
        end

        // 1. Reset with in_valid held high
        cycle(1'b1, 1'b1, 2'd2, 8'hEE, 4'hF);
        cycle(1'b1, 1'b1, 2'd2, 8'hEE, 4'hF);
        chk("reset_out_valid", {60'd0, out_valid}, 64'd0);
        chk("reset_out_data", {32'd0, out_data}, 64'd0);
        chk("reset_stat", {32'd0, stat_cnt}, 64'd0);

        // 2. Routing to each channel
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 2'(i), 8'hA0 + 8'(i), 4'hF);
            chk("route_valid", {60'd0, out_valid}, 64'd1 << i);
            chk("route_data", {56'd0, out_data[i*DW +: DW]}, {56'd0, 8'hA0 + 8'(i)});
        end
        cycle(1'b0, 1'b0, 2'd0, 8'h00, 4'hF);
        chk("route_drain", {60'd0, out_valid}, 64'd0);

        // 3. Stall isolation on channel 1
        cycle(1'b0, 1'b1, 2'd1, 8'h55, 4'b1101);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 2'd1, 8'h66, 4'b1101);
            chk("stall_blocked", {63'd0, last_acc}, 64'd0);
            chk("stall_hold", {56'd0, out_data[DW +: DW]}, 64'h55);
        end
        cycle(1'b0, 1'b1, 2'd1, 8'h66, 4'b1111);
        chk("stall_refill_acc", {63'd0, last_acc}, 64'd1);
        chk("stall_refill_valid", {63'd0, out_valid[1]}, 64'd1);
        chk("stall_refill_data", {56'd0, out_data[DW +: DW]}, 64'h66);
        cycle(1'b0, 1'b1, 2'd2, 8'h77, 4'b1101);
        chk("stall_other_acc", {63'd0, last_acc}, 64'd1);
        cycle(1'b0, 1'b0, 2'd0, 8'h00, 4'hF);
        cycle(1'b0, 1'b0, 2'd0, 8'h00, 4'hF);

        // 4. Full throughput on channel 0
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, 2'd0, 8'h10 + 8'(i), 4'b0001);
            chk("thru_acc", {63'd0, last_acc}, 64'd1);
            chk("thru_data", {56'd0, out_data[DW-1:0]}, {56'd0, 8'h10 + 8'(i)});
        end
        cycle(1'b0, 1'b0, 2'd0, 8'h00, 4'b0001);

        // 5. Reset while all channels are full and stalled
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 2'(i), 8'hC0 + 8'(i), 4'h0);
        chk("full_all", {60'd0, out_valid}, 64'hF);
        cycle(1'b1, 1'b0, 2'd0, 8'h00, 4'h0);
        chk("midrst_valid", {60'd0, out_valid}, 64'd0);
        chk("midrst_stat", {32'd0, stat_cnt}, 64'd0);
        cycle(1'b0, 1'b0, 2'd0, 8'h00, 4'hF);
        cycle(1'b0, 1'b0, 2'd0, 8'h00, 4'hF);

        // 6. Counter wrap on channel 3
        for (int i = 0; i < 260; i++) cycle(1'b0, 1'b1, 2'd3, 8'(i), 4'b1000);
        cycle(1'b0, 1'b0, 2'd0, 8'h00, 4'b1000);
`ifdef DEMUX_STATS_EN
        chk("wrap_cnt3", {56'd0, stat_cnt[31:24]}, 64'd4);
`else
        chk("stats_off", {32'd0, stat_cnt}, 64'd0);
`endif

        // Randomized traffic; the producer holds each word until it is accepted
        pend = 1'b0; p_sel = 2'd0; p_dat = '0; guard = 0;
        for (int i = 0; i < 400; i++) begin
            if (!pend && ($urandom_range(0, 3) != 0)) begin
                pend  = 1'b1;
                p_sel = 2'($urandom_range(0, 3));
                p_dat = 8'($urandom);
            end
            cycle(1'b0, pend, p_sel, pend ? p_dat : 8'($urandom), 4'($urandom));
            if (last_acc) begin
                pend = 1'b0;
                guard = 0;
            end else if (pend) begin
                guard++;
            end else begin
                guard = 0;
            end
            if (guard > 200) begin
                chk("producer_timeout", 64'd1, 64'd0);
                break;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
